aes_engine: RTL and testbench
=============================

// Module: aes_engine
// PURPOSE
// Iterative AES encryption engine, FIPS-197: one round per cycle.
// Key length is selectable at run time: 128, 192 or 256 bits (Nr = 10/12/14).
// Blocks move over valid/ready streams, and the output stalls under backpressure.
// Sits between the HSM register/DMA front end and the cipher-mode logic; keys are expanded on-chip.
// PARAMETERS
// KEY_MAX_BITS  256  largest key supported (128|192|256); modes above it are rejected; sizes W[] = 4*(KEY_MAX_Nr+1)
// PORTS
// clk          in   1    clock
// rst_n        in   1    reset, asynchronous, active-low
// key          in   256  key, MSB-aligned: AES-128 uses key[255:128], AES-192 uses key[255:64]
// key_len      in   2    00=128, 01=192, 10=256, 11=reserved
// key_valid    in   1    key load request; sampled only when key_ready=1
// key_ready    out  1    engine can accept a key (IDLE, READY, ERR)
// key_err      out  1    1-cycle pulse: key_len reserved or above KEY_MAX_BITS
// in_data      in   128  plaintext block
// in_valid     in   1    plaintext valid
// in_ready     out  1    high in READY only
// out_data     out  128  ciphertext, held while out_valid=1
// out_valid    out  1    ciphertext valid; cleared on out_valid&&out_ready
// out_ready    in   1    consumer accepts out_data
// busy         out  1    KEY_EXP or ENC in progress
// clear        in   1    synchronous flush: state->IDLE, key invalidated, out_valid->0
// BEHAVIOUR
// - Reset/clear: all outputs 0 except key_ready=1; state IDLE; out_data=0; W[] contents don't-care.
// - States: IDLE, KEY_EXP, READY, ENC, ERR. ERR lasts one cycle, then goes to IDLE.
// - IDLE/READY + key_valid, legal len: load W[0..Nk-1] from key; i<=Nk; imod<=0; enter KEY_EXP.
//   busy=1; key_ready=0. An illegal len takes IDLE/READY -> ERR; key_err pulses and the old key is discarded.
// - KEY_EXP: one word per cycle, Nk=4/6/8.
//   W[i] = W[i-Nk] ^ t, where imod = i mod Nk (counter, no divider).
//   imod==0 -> t = SubWord(RotWord(W[i-1])) ^ Rcon[i/Nk].
//   Nk==8 and imod==4 -> t = SubWord(W[i-1]); else t = W[i-1].
//   Rcon = 01,02,04,08,10,20,40,80,1b,36 (high byte).
//   Last word is 4*Nr+3 -> READY. Duration 40/46/52 cycles for 128/192/256.
// - READY: in_ready=1. key_valid has priority over in_valid in the same cycle (key taken, block not taken).
// - Accept at edge T (in_valid&&in_ready): s <= in_data ^ RK0; round<=1; enter ENC.
// - ENC rounds 1..Nr-1: s <= MixCol(ShiftRows(SubBytes(s))) ^ RK[round].
//   Final round Nr: out_data <= ShiftRows(SubBytes(s)) ^ RK[Nr]; out_valid<=1; return to READY.
// - Latency: out_valid rises Nr+1 cycles after acceptance, so 11/13/15.
//   Throughput: one block per Nr+1 cycles with no backpressure.
// - Backpressure: if out_valid && !out_ready at round Nr, ENC holds in round Nr and s is frozen.
//   The result is written on the cycle out_ready frees the slot (out_valid stays 1, out_data updates).
//   Data is never overwritten and never lost.
// - out_valid is cleared on out_valid&&out_ready unless a new result lands on the same edge.
//   If a new result lands on that edge, out_valid stays 1 with the new data.
// - key_valid during KEY_EXP/ENC is ignored (key_ready=0). clear mid-operation aborts; a partial block is dropped.
// - Round-key mux indexes W[4r..4r+3]; RK[r] is byte 0 = W[4r][31:24]. Byte order follows FIPS-197 column-major.
// - Datapath: 16 SubBytes S-boxes plus 4 key-schedule S-boxes, all combinational; a single always_ff FSM.
// TESTING
// - FIPS-197 C.1: key 000102..0f, len=00, pt 00112233445566778899aabbccddeeff.
//   -> out 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid 11 cycles after accept; key exp 40 cycles.
// - C.2: key 000102..17, len=01, same pt -> dda97ca4864cdfe06eaf70a0ec0d7191, latency 13.
// - C.3: key 000102..1f, len=10, same pt -> 8ea2b7ca516745bfeafc49904b496089, latency 15.
// - Backpressure: hold out_ready=0, push 2 blocks (C.3).
//   -> first out held stable and the engine stalls in round 14.
//   -> on out_ready=1 both results come out in order, none lost.
// - len=11 (or len=10 with KEY_MAX_BITS=128) -> key_err pulse 1 cycle, ERR then IDLE, in_ready stays 0.
// - clear at round 5, and rst_n low during KEY_EXP -> IDLE, out_valid=0, key_ready=1.
//   Re-keying with C.1 then gives the correct ciphertext.

Source files
------------

// File: rtl/aes_if.sv
// AES engine stream interface: key load, plaintext in,
// ciphertext out, plus status and flush.
interface aes_if;
  logic [255:0] key;
  logic [1:0]   key_len;
  logic         key_valid;
  logic         key_ready;
  logic         key_err;
  logic [127:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         clear;

  modport master (
    output key, key_len, key_valid,
    output in_data, in_valid,
    output out_ready, clear,
    input  key_ready, key_err, in_ready,
    input  out_data, out_valid, busy
  );

  modport slave (
    input  key, key_len, key_valid,
    input  in_data, in_valid,
    input  out_ready, clear,
    output key_ready, key_err, in_ready,
    output out_data, out_valid, busy
  );
endinterface

// File: rtl/aes_engine.sv
// Iterative AES-128/192/256 encryptor, one round per cycle,
// with on-chip key expansion and a stallable output slot.
module aes_engine #(
  parameter int KEY_MAX_BITS = 256
) (
  input  logic clk,
  input  logic rst_n,
  aes_if.slave bus
);
  localparam int MAX_NR = (KEY_MAX_BITS >= 256) ? 14 :
                          (KEY_MAX_BITS >= 192) ? 12 : 10;
  localparam int WN = 4 * (MAX_NR + 1);

  typedef enum logic [2:0] {
    IDLE, KEY_EXP, READY, ENC, ERR
  } state_t;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // x^254 is the field inverse (and maps 0 to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int k = 0; k < 7; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] a;
    a = gf_inv(x);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]}
             ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]),
            sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] x);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++)
      o[8*k +: 8] = sbox(x[8*k +: 8]);
    return o;
  endfunction

  // byte k sits at [127-8k -: 8]; row r, col c is byte r+4c
  function automatic logic [127:0] shift_rows(input logic [127:0] x);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = x[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] x);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = x[127-32*c -: 8];
      a1 = x[119-32*c -: 8];
      a2 = x[111-32*c -: 8];
      a3 = x[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  state_t state, state_nx;

  logic [31:0]  w [WN];
  logic [127:0] s;
  logic [127:0] out_data_q;
  logic         out_valid_q;
  logic [3:0]   round;
  logic [3:0]   nk;
  logic [3:0]   nr;
  logic [3:0]   nk_new;
  logic [3:0]   nr_new;
  logic [5:0]   i;
  logic [2:0]   imod;
  logic [7:0]   rc;

  logic         len_ok;
  logic         key_ready_c;
  logic         in_ready_c;
  logic         key_take;
  logic         in_take;
  logic         final_go;

  logic [31:0]  prev;
  logic [31:0]  back;
  logic [31:0]  kin;
  logic [31:0]  ksub;
  logic [31:0]  t;
  logic [5:0]   rk_base;
  logic [127:0] rk;
  logic [127:0] rk0;
  logic [127:0] sr;
  logic [127:0] mc;

  always_comb begin
    len_ok = 1'b0;
    nk_new = 4'd4;
    nr_new = 4'd10;
    unique case (bus.key_len)
      2'b00: len_ok = 1'b1;
      2'b01: begin
        len_ok = (KEY_MAX_BITS >= 192);
        nk_new = 4'd6;
        nr_new = 4'd12;
      end
      2'b10: begin
        len_ok = (KEY_MAX_BITS >= 256);
        nk_new = 4'd8;
        nr_new = 4'd14;
      end
      default: len_ok = 1'b0;
    endcase
  end

  assign key_take = bus.key_valid && key_ready_c && len_ok;
  assign in_take  = bus.in_valid && in_ready_c;
  assign final_go = (state == ENC) && (round == nr)
                 && (!out_valid_q || bus.out_ready);

  assign prev = w[i - 6'd1];
  assign back = w[i - {2'b00, nk}];
  assign kin  = (imod == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
  assign ksub = sub_word(kin);

  always_comb begin
    t = prev;
    unique case (1'b1)
      (imod == 3'd0): t = ksub ^ {rc, 24'h0};
      (nk == 4'd8 && imod == 3'd4): t = ksub;
      default: t = prev;
    endcase
  end

  assign rk_base = {round, 2'b00};
  assign rk  = {w[rk_base], w[rk_base + 6'd1],
                w[rk_base + 6'd2], w[rk_base + 6'd3]};
  assign rk0 = {w[0], w[1], w[2], w[3]};
  assign sr  = shift_rows(sub_bytes(s));
  assign mc  = mix_columns(sr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus.clear) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE, ERR: begin
          if (bus.key_valid)
            state_nx = len_ok ? KEY_EXP : ERR;
          else
            state_nx = IDLE;
        end
        READY: begin
          if (bus.key_valid)
            state_nx = len_ok ? KEY_EXP : ERR;
          else if (bus.in_valid)
            state_nx = ENC;
        end
        KEY_EXP: if (i == {nr, 2'b11}) state_nx = READY;
        ENC:     if (final_go) state_nx = READY;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    key_ready_c = (state == IDLE) || (state == READY)
               || (state == ERR);
    in_ready_c  = (state == READY) && !bus.key_valid;
  end

  assign bus.key_ready = key_ready_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = (state == KEY_EXP) || (state == ENC);
  assign bus.key_err   = (state == ERR);
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

  // key words land here; the schedule fills one word per cycle
  always_ff @(posedge clk) begin
    if (key_take && !bus.clear) begin
      w[0] <= bus.key[255:224];
      w[1] <= bus.key[223:192];
      w[2] <= bus.key[191:160];
      w[3] <= bus.key[159:128];
      w[4] <= bus.key[127:96];
      w[5] <= bus.key[95:64];
      w[6] <= bus.key[63:32];
      w[7] <= bus.key[31:0];
    end else if (state == KEY_EXP) begin
      w[i] <= back ^ t;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s           <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      round       <= 4'd0;
      nk          <= 4'd4;
      nr          <= 4'd10;
      i           <= 6'd0;
      imod        <= 3'd0;
      rc          <= 8'h01;
    end else if (bus.clear) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      round       <= 4'd0;
    end else begin
      if (out_valid_q && bus.out_ready)
        out_valid_q <= 1'b0;
      if (key_take) begin
        nk   <= nk_new;
        nr   <= nr_new;
        i    <= {2'b00, nk_new};
        imod <= 3'd0;
        rc   <= 8'h01;
      end
      if (state == KEY_EXP) begin
        i <= i + 6'd1;
        if ({1'b0, imod} == nk - 4'd1) imod <= 3'd0;
        else                           imod <= imod + 3'd1;
        if (imod == 3'd0) rc <= xt(rc);
      end
      if (in_take) begin
        s     <= bus.in_data ^ rk0;
        round <= 4'd1;
      end
      // final round waits here while the output slot is full
      if (state == ENC) begin
        if (round != nr) begin
          s     <= mc ^ rk;
          round <= round + 4'd1;
        end else if (final_go) begin
          out_data_q  <= sr ^ rk;
          out_valid_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_aes_engine.sv
// Scoreboard bench for aes_engine using the FIPS-197
// appendix C vectors, backpressure, errors and flushes.
module tb_aes_engine;
  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   n_out;
  logic [127:0] exp_q[$];
  logic         hold;
  logic [127:0] hold_data;

  aes_if bus();

  aes_engine #(.KEY_MAX_BITS(256)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  localparam logic [255:0] K1 =
    256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
  localparam logic [255:0] K2 =
    256'h000102030405060708090a0b0c0d0e0f_1011121314151617_0000000000000000;
  localparam logic [255:0] K3 =
    256'h000102030405060708090a0b0c0d0e0f_101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string nm,
    input logic [127:0] act,
    input logic [127:0] want
  );
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold <= 1'b0;
    end else begin
      if (hold) begin
        chk("held valid", 128'(bus.out_valid), 128'd1);
        chk("held data", bus.out_data, hold_data);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          tmo("unexpected output");
        end else begin
          chk("ciphertext", bus.out_data, exp_q.pop_front());
        end
        n_out++;
      end
      hold      <= bus.out_valid && !bus.out_ready;
      hold_data <= bus.out_data;
    end
  end

  task automatic load_key(
    input logic [255:0] k,
    input logic [1:0] len,
    input int dur
  );
    bit ok;
    int cnt;
    bus.key       = k;
    bus.key_len   = len;
    bus.key_valid = 1'b1;
    ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (bus.key_ready) ok = 1;
    end
    if (!ok) tmo("key accept");
    tick();
    bus.key_valid = 1'b0;
    if (dur > 0) begin
      cnt = 0;
      ok  = 0;
      for (int n = 0; n < 100 && !ok; n++) begin
        @(negedge clk);
        if (bus.busy) cnt++;
        else          ok = 1;
      end
      if (!ok) tmo("key expansion");
      chk("keyexp cycles", 128'(cnt), 128'(dur));
      chk("ready after keyexp", 128'(bus.in_ready), 128'd1);
      tick();
    end
  endtask

  task automatic send(
    input logic [127:0] pt,
    input logic [127:0] want,
    input int lat,
    input bit push
  );
    bit ok;
    int c0;
    bus.in_data  = pt;
    bus.in_valid = 1'b1;
    ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
    end
    if (!ok) begin
      tmo("block accept");
      tick();
      bus.in_valid = 1'b0;
      return;
    end
    c0 = cyc;
    if (push) exp_q.push_back(want);
    tick();
    bus.in_valid = 1'b0;
    if (lat > 0) begin
      ok = 0;
      for (int n = 0; n < 60 && !ok; n++) begin
        @(negedge clk);
        if (bus.out_valid) ok = 1;
      end
      if (!ok) tmo("output latency");
      else chk("latency", 128'(cyc - c0), 128'(lat));
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    checks        = 0;
    errors        = 0;
    n_out         = 0;
    rst_n         = 1'b0;
    bus.key       = '0;
    bus.key_len   = 2'b00;
    bus.key_valid = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.clear     = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst key_ready", 128'(bus.key_ready), 128'd1);
    chk("rst in_ready", 128'(bus.in_ready), 128'd0);
    chk("rst out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst busy", 128'(bus.busy), 128'd0);
    chk("rst key_err", 128'(bus.key_err), 128'd0);
    chk("rst out_data", bus.out_data, 128'd0);
    tick();

    load_key(K1, 2'b00, 40);
    send(PT, C1, 11, 1);
    load_key(K2, 2'b01, 46);
    send(PT, C2, 13, 1);
    load_key(K3, 2'b10, 52);
    send(PT, C3, 15, 1);

    bus.out_ready = 1'b0;
    n0 = n_out;
    send(PT, C3, 0, 1);
    send(PT, C3, 0, 1);
    repeat (20) tick();
    @(negedge clk);
    chk("stall busy", 128'(bus.busy), 128'd1);
    chk("stall in_ready", 128'(bus.in_ready), 128'd0);
    chk("stall out_valid", 128'(bus.out_valid), 128'd1);
    chk("stall out_data", bus.out_data, C3);
    tick();
    bus.out_ready = 1'b1;
    repeat (5) tick();
    chk("bp outputs", 128'(n_out - n0), 128'd2);
    chk("bp out_valid", 128'(bus.out_valid), 128'd0);

    load_key(K1, 2'b00, 40);
    load_key(K3, 2'b11, 0);
    @(negedge clk);
    chk("err pulse", 128'(bus.key_err), 128'd1);
    chk("err in_ready", 128'(bus.in_ready), 128'd0);
    chk("err busy", 128'(bus.busy), 128'd0);
    @(negedge clk);
    chk("err end", 128'(bus.key_err), 128'd0);
    chk("err key_ready", 128'(bus.key_ready), 128'd1);
    chk("err idle in_ready", 128'(bus.in_ready), 128'd0);
    tick();

    load_key(K1, 2'b00, 40);
    send(PT, 128'd0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    @(negedge clk);
    chk("clr out_valid", 128'(bus.out_valid), 128'd0);
    chk("clr out_data", bus.out_data, 128'd0);
    chk("clr key_ready", 128'(bus.key_ready), 128'd1);
    chk("clr busy", 128'(bus.busy), 128'd0);
    chk("clr in_ready", 128'(bus.in_ready), 128'd0);
    tick();
    load_key(K1, 2'b00, 40);
    send(PT, C1, 11, 1);

    load_key(K2, 2'b01, 0);
    repeat (10) tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("arst busy", 128'(bus.busy), 128'd0);
    chk("arst key_ready", 128'(bus.key_ready), 128'd1);
    chk("arst out_valid", 128'(bus.out_valid), 128'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post rst key_ready", 128'(bus.key_ready), 128'd1);
    chk("post rst in_ready", 128'(bus.in_ready), 128'd0);
    tick();
    load_key(K1, 2'b00, 40);
    send(PT, C1, 11, 1);

    repeat (5) tick();
    chk("queue drained", 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
